// File: rtl/uart_byte_tx_if.sv
// Byte handshake between the message selector and the UART transmitter.
interface uart_byte_tx_if;
   logic       send_en;
   logic [7:0] data_rx;
   logic       uart_tx;
   logic       tx_busy;
   logic       over_tx;

   // Selector side: issues byte requests and watches for frame completion.
   modport master (
      output send_en,
      output data_rx,
      input  uart_tx,
      input  tx_busy,
      input  over_tx
   );

   // Transmitter side.
   modport slave (
      input  send_en,
      input  data_rx,
      output uart_tx,
      output tx_busy,
      output over_tx
   );
endinterface

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8-bit LSB-first UART transmitter, optional parity, 1 or 2 stop bits.
// over_tx is raised during the last cycle of the final stop bit, so a selector
// that answers it with a registered send_en gets its next byte accepted on the
// first IDLE cycle, leaving exactly one idle-high cycle between frames.
module uart_byte_tx #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 9600,
   parameter bit PARITY_EN  = 1'b0,
   parameter bit PARITY_ODD = 1'b0,
   parameter int STOP_BITS  = 1
) (
   input logic           clk,
   input logic           rst_n,
   uart_byte_tx_if.slave bus
);
   localparam int DIV   = CLK_FREQ / BAUD;
   localparam int CNT_W = $clog2(DIV);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(DIV - 2);
   localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic             stop_idx;
   logic [7:0]       shreg;
   logic             par_bit;
   logic             tx_q;
   logic             busy_q;
   logic             over_q;
   logic             bit_end;

   assign bit_end     = (cnt == CNT_LAST);
   assign bus.uart_tx = tx_q;
   assign bus.tx_busy = busy_q;
   assign bus.over_tx = over_q;

   // Frame sequencer: owns state, baud counter, shifter and all registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         shreg    <= '0;
         par_bit  <= 1'b0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         over_q   <= 1'b0;
      end else begin
         over_q <= 1'b0;
         if (state != IDLE)
            cnt <= bit_end ? '0 : cnt + 1'b1;
         case (state)
            IDLE: begin
               // Parity is taken from the byte at acceptance; later data_rx
               // activity cannot disturb it.
               if (bus.send_en) begin
                  shreg   <= bus.data_rx;
                  par_bit <= (^bus.data_rx) ^ PARITY_ODD;
                  cnt     <= '0;
                  state   <= START;
                  tx_q    <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            START: begin
               if (bit_end) begin
                  state   <= DATA;
                  bit_idx <= '0;
                  tx_q    <= shreg[0];
               end
            end
            DATA: begin
               if (bit_end) begin
                  shreg   <= {1'b0, shreg[7:1]};
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) begin
                     stop_idx <= 1'b0;
                     if (PARITY_EN) begin
                        state <= PARITY;
                        tx_q  <= par_bit;
                     end else begin
                        state <= STOP;
                        tx_q  <= 1'b1;
                     end
                  end else begin
                     tx_q <= shreg[1];
                  end
               end
            end
            PARITY: begin
               if (bit_end) begin
                  state <= STOP;
                  tx_q  <= 1'b1;
               end
            end
            STOP: begin
               if (stop_idx == STOP_LAST && cnt == CNT_PRE)
                  over_q <= 1'b1;
               if (bit_end) begin
                  if (stop_idx == STOP_LAST) begin
                     state  <= IDLE;
                     busy_q <= 1'b0;
                  end else begin
                     stop_idx <= stop_idx + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
